// File: rtl/ide_taskfile.sv
// ATA PIO task file with a 256x16 sector buffer, bridging the emulated
// CPU's IDE podule and HPS firmware that services the commands.
module ide_taskfile #(
  parameter int BUF_AW = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [3:0]  cpu_addr,
  input  logic        cpu_sel,
  input  logic        cpu_we,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_irq,
  input  logic [4:0]  hps_addr,
  input  logic        hps_rd,
  input  logic        hps_wr,
  input  logic [15:0] hps_din,
  output logic [15:0] hps_dout,
  output logic [5:0]  hps_req
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_PIO_IN,
    S_PIO_OUT
  } state_e;

  localparam logic [BUF_AW:0]   PTR_ONE = 1;
  localparam logic [BUF_AW-1:0] LOW_ONE = 1;

  state_e state_q, state_d;

  logic [7:0]  status_q, status_d;
  logic [7:0]  error_q, error_d;
  logic [7:0]  feature_q, feature_d;
  logic [7:0]  command_q, command_d;
  logic [7:0]  tf_q [2:6];
  logic [7:0]  tf_d [2:6];
  logic        nien_q, nien_d;
  logic        srst_q, srst_d;
  logic        irq_q, irq_d;
  logic        req0_q, req0_d;
  logic        req1_q, req1_d;
  logic [BUF_AW:0] ptr_q, ptr_d;
  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic [15:0] hps_dout_q, hps_dout_d;

  logic [15:0] mem_q [0:(1<<BUF_AW)-1];
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rd;

  logic cpu_rd, cpu_wr, bsy, last;
  logic srst_rise, cmd_wr, hps_st_wr, st_rd;
  logic cpu_dat_rd, cpu_dat_wr, hps_dat_rd, hps_dat_wr;

  assign cpu_rd     = cpu_sel & ~cpu_we;
  assign cpu_wr     = cpu_sel & cpu_we;
  assign bsy        = status_q[7];
  assign last       = &ptr_q[BUF_AW-1:0];
  assign mem_rd     = mem_q[ptr_q[BUF_AW-1:0]];
  assign srst_rise  = cpu_wr & (cpu_addr == 4'hE) & cpu_din[2] & ~srst_q;
  assign cmd_wr     = cpu_wr & (cpu_addr == 4'd7) & (state_q == S_IDLE);
  assign hps_st_wr  = hps_wr & (hps_addr == 5'd7) & ~cmd_wr;
  assign st_rd      = cpu_rd & (cpu_addr == 4'd7);
  assign cpu_dat_rd = cpu_rd & (cpu_addr == 4'd0) & (state_q == S_PIO_IN);
  assign cpu_dat_wr = cpu_wr & (cpu_addr == 4'd0) & (state_q == S_PIO_OUT);
  assign hps_dat_rd = hps_rd & (hps_addr == 5'h0F) & (state_q == S_CMD);
  assign hps_dat_wr = hps_wr & (hps_addr == 5'h0F) & (state_q == S_CMD);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      status_q   <= 8'h50;
      error_q    <= 8'h00;
      feature_q  <= 8'h00;
      command_q  <= 8'h00;
      tf_q[2]    <= 8'h01;
      tf_q[3]    <= 8'h01;
      tf_q[4]    <= 8'h00;
      tf_q[5]    <= 8'h00;
      tf_q[6]    <= 8'h00;
      nien_q     <= 1'b0;
      srst_q     <= 1'b0;
      irq_q      <= 1'b0;
      req0_q     <= 1'b0;
      req1_q     <= 1'b0;
      ptr_q      <= '0;
      cpu_dout_q <= 16'h0;
      hps_dout_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      error_q    <= error_d;
      feature_q  <= feature_d;
      command_q  <= command_d;
      tf_q       <= tf_d;
      nien_q     <= nien_d;
      srst_q     <= srst_d;
      irq_q      <= irq_d;
      req0_q     <= req0_d;
      req1_q     <= req1_d;
      ptr_q      <= ptr_d;
      cpu_dout_q <= cpu_dout_d;
      hps_dout_q <= hps_dout_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (mem_we) mem_q[ptr_q[BUF_AW-1:0]] <= mem_wdata;
  end

  always_comb begin
    state_d = state_q;
    if (srst_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_wr) state_d = S_CMD;
        S_CMD: begin
          if (hps_st_wr) begin
            if (hps_din[3] & ~hps_din[7])
              state_d = hps_din[8] ? S_PIO_IN : S_PIO_OUT;
            else if (~hps_din[3] & ~hps_din[7])
              state_d = S_IDLE;
          end
        end
        S_PIO_IN:  if (cpu_dat_rd & last) state_d = S_CMD;
        S_PIO_OUT: if (cpu_dat_wr & last) state_d = S_CMD;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    status_d  = status_q;
    error_d   = error_q;
    feature_d = feature_q;
    command_d = command_q;
    tf_d      = tf_q;
    nien_d    = nien_q;
    srst_d    = srst_q;
    irq_d     = irq_q;
    req0_d    = req0_q;
    req1_d    = req1_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_wdata = hps_din;

    // HPS first so a same-cycle CPU write to a shared reg wins
    if (hps_wr) begin
      if (hps_addr == 5'd1) error_d = hps_din[7:0];
      if (hps_addr >= 5'd2 && hps_addr <= 5'd6)
        tf_d[hps_addr[2:0]] = hps_din[7:0];
    end
    if (cpu_wr & ~bsy) begin
      if (cpu_addr == 4'd1) feature_d = cpu_din[7:0];
      if (cpu_addr >= 4'd2 && cpu_addr <= 4'd6)
        tf_d[cpu_addr[2:0]] = cpu_din[7:0];
    end
    if (cpu_wr && cpu_addr == 4'hE) begin
      nien_d = cpu_din[1];
      srst_d = cpu_din[2];
    end

    if (st_rd) irq_d = 1'b0;
    if (hps_st_wr) begin
      status_d = hps_din[7:0];
      req0_d   = 1'b0;
      req1_d   = 1'b0;
      if (hps_din[9]) irq_d = 1'b1;
    end
    if (cmd_wr) begin
      command_d = cpu_din[7:0];
      status_d  = {1'b1, status_q[6:4], 1'b0, status_q[2:0]};
      req0_d    = 1'b1;
    end

    if (hps_dat_wr) mem_we = 1'b1;
    if (cpu_dat_wr) begin
      mem_we    = 1'b1;
      mem_wdata = cpu_din;
    end
    if ((cpu_dat_rd | cpu_dat_wr) & last) begin
      status_d = {1'b1, status_q[6:4], 1'b0, status_q[2:0]};
      req0_d   = 1'b1;
      if (cpu_dat_wr) req1_d = 1'b1;
    end

    if (cpu_dat_rd | cpu_dat_wr)
      ptr_d = ptr_q + PTR_ONE;
    if (hps_dat_rd | hps_dat_wr)
      ptr_d = {1'b0, ptr_q[BUF_AW-1:0] + LOW_ONE};
    if (state_d != state_q || hps_st_wr)
      ptr_d = '0;

    if (srst_rise) begin
      status_d  = 8'h50;
      error_d   = 8'h00;
      feature_d = 8'h00;
      command_d = 8'h00;
      tf_d[2]   = 8'h01;
      tf_d[3]   = 8'h01;
      tf_d[4]   = 8'h00;
      tf_d[5]   = 8'h00;
      tf_d[6]   = 8'h00;
      irq_d     = 1'b0;
      req0_d    = 1'b0;
      req1_d    = 1'b0;
      ptr_d     = '0;
      mem_we    = 1'b0;
    end
  end

  always_comb begin
    cpu_dout_d = cpu_dout_q;
    if (cpu_rd) begin
      case (cpu_addr)
        4'd0:    cpu_dout_d = (state_q == S_PIO_IN) ? mem_rd : 16'h0;
        4'd1:    cpu_dout_d = {8'h0, error_q};
        4'd2, 4'd3, 4'd4, 4'd5, 4'd6:
                 cpu_dout_d = {8'h0, tf_q[cpu_addr[2:0]]};
        4'd7, 4'hE:
                 cpu_dout_d = {8'h0, status_q};
        default: cpu_dout_d = 16'h0;
      endcase
    end
    case (hps_addr)
      5'd0, 5'h0F: hps_dout_d = mem_rd;
      5'd1:        hps_dout_d = {8'h0, feature_q};
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6:
                   hps_dout_d = {8'h0, tf_q[hps_addr[2:0]]};
      5'd7:        hps_dout_d = {8'h0, command_q};
      default:     hps_dout_d = 16'h0;
    endcase
  end

  assign cpu_dout = cpu_dout_q;
  assign hps_dout = hps_dout_q;
  assign cpu_irq  = irq_q & ~nien_q;
  assign hps_req  = {3'b000, irq_q, req1_q, req0_q};

endmodule

// File: tb/tb_ide_taskfile.sv
// Directed bench for ide_taskfile: register table plus PIO in/out,
// nIEN, same-cycle collisions, SRST and mid-transfer reset sequences.
module tb_ide_taskfile;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [3:0]  cpu_addr;
  logic        cpu_sel;
  logic        cpu_we;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_irq;
  logic [4:0]  hps_addr;
  logic        hps_rd;
  logic        hps_wr;
  logic [15:0] hps_din;
  logic [15:0] hps_dout;
  logic [5:0]  hps_req;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk_sys = ~clk_sys;

  ide_taskfile dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .cpu_addr (cpu_addr),
    .cpu_sel  (cpu_sel),
    .cpu_we   (cpu_we),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_irq  (cpu_irq),
    .hps_addr (hps_addr),
    .hps_rd   (hps_rd),
    .hps_wr   (hps_wr),
    .hps_din  (hps_din),
    .hps_dout (hps_dout),
    .hps_req  (hps_req)
  );

  typedef struct {
    bit          hps;
    bit          we;
    logic [4:0]  addr;
    logic [15:0] din;
    logic [15:0] exp;
    logic [5:0]  req;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [15:0] d);
    cpu_addr = a; cpu_din = d; cpu_sel = 1'b1; cpu_we = 1'b1;
    @(negedge clk_sys);
    cpu_sel = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [15:0] d);
    cpu_addr = a; cpu_sel = 1'b1; cpu_we = 1'b0;
    @(negedge clk_sys);
    cpu_sel = 1'b0;
    d = cpu_dout;
  endtask

  task automatic hps_write(input logic [4:0] a, input logic [15:0] d);
    hps_addr = a; hps_din = d; hps_wr = 1'b1;
    @(negedge clk_sys);
    hps_wr = 1'b0;
  endtask

  task automatic hps_read(input logic [4:0] a, output logic [15:0] d);
    hps_addr = a;
    @(negedge clk_sys);
    d = hps_dout;
  endtask

  task automatic hps_pop(output logic [15:0] d);
    hps_addr = 5'h0F; hps_rd = 1'b1;
    @(negedge clk_sys);
    hps_rd = 1'b0;
    d = hps_dout;
  endtask

  initial begin
    logic [15:0] d;
    int bad;

    tv[0]  = '{0, 0, 5'h7, 16'h0,    16'h0050, 6'h00};
    tv[1]  = '{0, 0, 5'h2, 16'h0,    16'h0001, 6'h00};
    tv[2]  = '{0, 0, 5'h3, 16'h0,    16'h0001, 6'h00};
    tv[3]  = '{0, 0, 5'h1, 16'h0,    16'h0000, 6'h00};
    tv[4]  = '{0, 1, 5'h2, 16'h00AB, 16'h0,    6'h00};
    tv[5]  = '{0, 0, 5'h2, 16'h0,    16'h00AB, 6'h00};
    tv[6]  = '{1, 0, 5'h2, 16'h0,    16'h00AB, 6'h00};
    tv[7]  = '{0, 1, 5'h1, 16'h0011, 16'h0,    6'h00};
    tv[8]  = '{1, 0, 5'h1, 16'h0,    16'h0011, 6'h00};
    tv[9]  = '{0, 0, 5'h1, 16'h0,    16'h0000, 6'h00};
    tv[10] = '{0, 0, 5'h0, 16'h0,    16'h0000, 6'h00};
    tv[11] = '{0, 0, 5'h8, 16'h0,    16'h0000, 6'h00};
    tv[12] = '{1, 1, 5'h4, 16'h0077, 16'h0,    6'h00};
    tv[13] = '{0, 0, 5'h4, 16'h0,    16'h0077, 6'h00};
    tv[14] = '{0, 1, 5'h7, 16'h0020, 16'h0,    6'h01};
    tv[15] = '{0, 0, 5'h7, 16'h0,    16'h00D0, 6'h01};
    tv[16] = '{0, 0, 5'hE, 16'h0,    16'h00D0, 6'h01};
    tv[17] = '{1, 0, 5'h7, 16'h0,    16'h0020, 6'h01};
    tv[18] = '{0, 1, 5'h3, 16'h0099, 16'h0,    6'h01};
    tv[19] = '{0, 0, 5'h3, 16'h0,    16'h0001, 6'h01};
    tv[20] = '{1, 1, 5'h1, 16'h0004, 16'h0,    6'h01};
    tv[21] = '{0, 0, 5'h1, 16'h0,    16'h0004, 6'h01};

    reset_n = 1'b0;
    cpu_addr = '0; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_din = '0;
    hps_addr = '0; hps_rd = 1'b0; hps_wr = 1'b0; hps_din = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_cpu_dout", cpu_dout, 16'h0);
    chk("rst_hps_dout", hps_dout, 16'h0);
    chk("rst_hps_req", {10'h0, hps_req}, 16'h0);
    chk("rst_cpu_irq", {15'h0, cpu_irq}, 16'h0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    for (int i = 0; i < NV; i++) begin
      if (tv[i].hps) begin
        if (tv[i].we) hps_write(tv[i].addr, tv[i].din);
        else begin
          hps_read(tv[i].addr, d);
          chk($sformatf("vec%0d_hps_rd", i), d, tv[i].exp);
        end
      end else begin
        if (tv[i].we) cpu_write(tv[i].addr[3:0], tv[i].din);
        else begin
          cpu_read(tv[i].addr[3:0], d);
          chk($sformatf("vec%0d_cpu_rd", i), d, tv[i].exp);
        end
      end
      chk($sformatf("vec%0d_req", i), {10'h0, hps_req}, {10'h0, tv[i].req});
    end

    // PIO in: HPS fills buffer, CPU drains it
    for (int k = 0; k < 256; k++) begin
      hps_addr = 5'h0F; hps_din = 16'(k); hps_wr = 1'b1;
      @(negedge clk_sys);
    end
    hps_wr = 1'b0;
    hps_write(5'h07, 16'h0358);
    chk("pio_in_req", {10'h0, hps_req}, 16'h0004);
    chk("pio_in_irq", {15'h0, cpu_irq}, 16'h0001);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      cpu_read(4'd0, d);
      if (d !== 16'(k)) bad++;
    end
    chk("pio_in_bad_words", 16'(bad), 16'h0);
    chk("pio_in_done_req", {10'h0, hps_req}, 16'h0005);
    cpu_read(4'd7, d);
    chk("pio_in_done_st", d, 16'h00D0);
    chk("pio_in_irq_clr", {10'h0, hps_req}, 16'h0001);

    // PIO out: CPU fills buffer, HPS drains it
    hps_write(5'h07, 16'h0050);
    chk("idle_req", {10'h0, hps_req}, 16'h0000);
    cpu_write(4'd7, 16'h0030);
    hps_write(5'h07, 16'h0058);
    chk("pio_out_req", {10'h0, hps_req}, 16'h0000);
    for (int k = 0; k < 256; k++) cpu_write(4'd0, 16'hA500 + 16'(k));
    chk("pio_out_done_req", {10'h0, hps_req}, 16'h0003);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      hps_pop(d);
      if (d !== 16'hA500 + 16'(k)) bad++;
    end
    chk("pio_out_bad_words", 16'(bad), 16'h0);
    hps_write(5'h07, 16'h0250);
    chk("done_irq", {15'h0, cpu_irq}, 16'h0001);
    chk("done_req", {10'h0, hps_req}, 16'h0004);

    // nIEN masks the pin but keeps the pending bit
    cpu_write(4'hE, 16'h0002);
    chk("nien_irq", {15'h0, cpu_irq}, 16'h0000);
    chk("nien_req", {10'h0, hps_req}, 16'h0004);
    cpu_write(4'hE, 16'h0000);
    chk("unmask_irq", {15'h0, cpu_irq}, 16'h0001);
    cpu_read(4'hE, d);
    chk("alt_st", d, 16'h0050);
    chk("alt_keeps_irq", {15'h0, cpu_irq}, 16'h0001);
    cpu_read(4'd7, d);
    chk("st_idle", d, 16'h0050);
    chk("st_clears_irq", {15'h0, cpu_irq}, 16'h0000);

    // same-cycle command write and HPS status write
    cpu_addr = 4'd7; cpu_din = 16'h0020; cpu_sel = 1'b1; cpu_we = 1'b1;
    hps_addr = 5'h07; hps_din = 16'h0050; hps_wr = 1'b1;
    @(negedge clk_sys);
    cpu_sel = 1'b0; cpu_we = 1'b0; hps_wr = 1'b0;
    chk("coll_cmd_req", {10'h0, hps_req}, 16'h0001);
    hps_read(5'h07, d);
    chk("coll_cmd_latched", d, 16'h0020);

    // same-cycle status read and irq raise: irq ends set
    cpu_addr = 4'd7; cpu_sel = 1'b1; cpu_we = 1'b0;
    hps_addr = 5'h07; hps_din = 16'h0358; hps_wr = 1'b1;
    @(negedge clk_sys);
    cpu_sel = 1'b0; hps_wr = 1'b0;
    chk("coll_st_rd", cpu_dout, 16'h00D0);
    chk("coll_irq", {15'h0, cpu_irq}, 16'h0001);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      cpu_read(4'd0, d);
      if (d !== 16'hA500 + 16'(k)) bad++;
    end
    chk("pio_in100_bad", 16'(bad), 16'h0);

    // SRST mid-transfer
    cpu_write(4'hE, 16'h0004);
    chk("srst_irq", {15'h0, cpu_irq}, 16'h0000);
    chk("srst_req", {10'h0, hps_req}, 16'h0000);
    cpu_read(4'd7, d);
    chk("srst_st", d, 16'h0050);
    cpu_read(4'd0, d);
    chk("srst_data0", d, 16'h0000);
    cpu_read(4'd2, d);
    chk("srst_count", d, 16'h0001);
    cpu_read(4'd4, d);
    chk("srst_cyl", d, 16'h0000);
    hps_read(5'h00, d);
    chk("srst_ptr0", d, 16'hA500);
    hps_read(5'h07, d);
    chk("srst_cmd", d, 16'h0000);
    cpu_write(4'hE, 16'h0000);

    // reset_n mid-command
    cpu_write(4'd7, 16'h0020);
    chk("pre_rst_req", {10'h0, hps_req}, 16'h0001);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("mid_rst_req", {10'h0, hps_req}, 16'h0000);
    chk("mid_rst_dout", hps_dout, 16'h0000);
    reset_n = 1'b1;
    cpu_read(4'd7, d);
    chk("post_rst_st", d, 16'h0050);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
